// File: rtl/i2c_dac_pkg.sv
// i2c_dac_pkg: shared constants and FSM state encoding for the I2C DAC target.
package i2c_dac_pkg;
  localparam logic [6:0] DEF_ADDR  = 7'b110_0000;
  localparam logic [4:0] REG_0     = 5'd0;
  localparam logic [4:0] REG_1     = 5'd1;
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b11;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_CMD, ST_CMD_ACK,
    ST_DHI, ST_DHI_ACK, ST_DLO, ST_DLO_ACK, ST_RD, ST_RD_ACK
  } state_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-FF synchronizers for SCL/SDA plus SCL edge and START/STOP pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end
  assign o_sda      = r_sda_sync[1];
  assign o_scl_rise = r_scl_sync[1] & ~r_scl_d;
  assign o_scl_fall = ~r_scl_sync[1] & r_scl_d;
  assign o_start    = r_scl_sync[1] & r_scl_d & r_sda_d & ~r_sda_sync[1];
  assign o_stop     = r_scl_sync[1] & r_scl_d & ~r_sda_d & r_sda_sync[1];
endmodule

// File: rtl/i2c_dac_target.sv
// i2c_dac_target: I2C target decoding MCP47FEB-style DAC register writes.
// Define I2C_DAC_TARGET_READ_EN to enable register read-back (cmd 2'b11).
module i2c_dac_target
  import i2c_dac_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEF_ADDR,
  parameter int         NUM_REGS    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic [11:0] dac0_value,
  output logic [11:0] dac1_value,
  output logic        dac_update,
  output logic        dac_update_ch,
  output logic        busy,
  output logic        cmd_error
);
  logic w_sda, w_rise, w_fall, w_start, w_stop;
  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );
  state_t      r_state, w_state_nx;
  logic [6:0]  r_shift, w_shift_nx;
  logic [2:0]  r_bit, w_bit_nx;
  logic [4:0]  r_reg, w_reg_nx;
  logic [3:0]  r_dhi, w_dhi_nx;
  logic [11:0] r_dac0, w_dac0_nx, r_dac1, w_dac1_nx;
  logic        r_sda, w_sda_nx, r_upd, w_upd_nx, r_busy, w_busy_nx, r_err, w_err_nx;
  logic [7:0]  w_byte;
  logic        w_last, w_match, w_cmd_ok;
  assign w_byte = {r_shift, w_sda};
  assign w_last = w_rise && r_bit == 3'd7;
`ifdef I2C_DAC_TARGET_READ_EN
  logic        r_rd, w_rd_nx, r_lo, w_lo_nx;
  logic [7:0]  r_tx, w_tx_nx, w_hi, w_lo;
  logic [11:0] w_val;
  assign w_match  = w_byte[7:1] == TARGET_ADDR;
  assign w_cmd_ok = int'(w_byte[7:3]) < NUM_REGS && (w_byte[2:1] == CMD_WRITE || w_byte[2:1] == CMD_READ);
  assign w_val    = (r_reg == REG_1) ? r_dac1 : r_dac0;
  assign w_hi     = {4'b0000, w_val[11:8]};
  assign w_lo     = w_val[7:0];
`else
  assign w_match  = w_byte[7:1] == TARGET_ADDR && !w_byte[0];
  assign w_cmd_ok = int'(w_byte[7:3]) < NUM_REGS && w_byte[2:1] == CMD_WRITE;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_bit_nx   = r_bit;
    w_reg_nx   = r_reg;
    w_dhi_nx   = r_dhi;
    w_dac0_nx  = r_dac0;
    w_dac1_nx  = r_dac1;
    w_sda_nx   = r_sda;
    w_upd_nx   = 1'b0;
    w_err_nx   = r_err;
`ifdef I2C_DAC_TARGET_READ_EN
    w_rd_nx    = r_rd;
    w_lo_nx    = r_lo;
    w_tx_nx    = r_tx;
`endif
    if (w_stop) begin
      w_state_nx = ST_IDLE;
      w_sda_nx   = 1'b1;
    end else if (w_start) begin
      w_state_nx = ST_ADDR;
      w_bit_nx   = 3'd0;
      w_sda_nx   = 1'b1;
    end else begin
      if (w_rise) begin
        w_shift_nx = w_byte[6:0];
        w_bit_nx   = r_bit + 3'd1;
      end
      case (r_state)
        ST_ADDR: if (w_last) begin
          w_state_nx = w_match ? ST_ADDR_ACK : ST_IDLE;
`ifdef I2C_DAC_TARGET_READ_EN
          w_rd_nx    = w_byte[0];
`endif
        end
        ST_CMD: if (w_last) begin
          w_state_nx = w_cmd_ok ? ST_CMD_ACK : ST_IDLE;
          w_reg_nx   = w_cmd_ok ? w_byte[7:3] : r_reg;
          w_err_nx   = r_err | !w_cmd_ok;
        end
        ST_DHI: if (w_last) begin
          w_state_nx = ST_DHI_ACK;
          w_dhi_nx   = w_byte[3:0];
        end
        ST_DLO: if (w_last) begin
          w_state_nx = ST_DLO_ACK;
          w_dac0_nx  = (r_reg == REG_0) ? {r_dhi, w_byte} : r_dac0;
          w_dac1_nx  = (r_reg == REG_1) ? {r_dhi, w_byte} : r_dac1;
          w_upd_nx   = 1'b1;
        end
        // ACK pulls low on the first fall after the 8th bit and releases on the next one
        ST_ADDR_ACK, ST_CMD_ACK, ST_DHI_ACK, ST_DLO_ACK: if (w_fall) begin
          w_sda_nx = !r_sda;
          if (!r_sda) begin
            w_bit_nx   = 3'd0;
            w_state_nx = (r_state == ST_CMD_ACK) ? ST_DHI : (r_state == ST_DHI_ACK) ? ST_DLO : ST_CMD;
          end
`ifdef I2C_DAC_TARGET_READ_EN
          if (!r_sda && r_state == ST_ADDR_ACK && r_rd) begin
            w_state_nx = ST_RD;
            w_sda_nx   = w_hi[7];
            w_tx_nx    = {w_hi[6:0], 1'b1};
            w_lo_nx    = 1'b0;
          end
`endif
        end
`ifdef I2C_DAC_TARGET_READ_EN
        ST_RD: begin
          if (w_fall) begin
            w_sda_nx = r_tx[7];
            w_tx_nx  = {r_tx[6:0], 1'b1};
          end
          if (w_last) w_state_nx = ST_RD_ACK;
        end
        ST_RD_ACK: begin
          if (w_fall) w_sda_nx = 1'b1;
          if (w_rise) begin
            w_bit_nx   = 3'd0;
            w_state_nx = w_sda ? ST_IDLE : ST_RD;
            w_tx_nx    = r_lo ? w_hi : w_lo;
            w_lo_nx    = !r_lo;
          end
        end
`endif
        default: ;
      endcase
    end
    w_busy_nx = (w_state_nx == ST_IDLE) ? 1'b0 : (w_state_nx == ST_ADDR_ACK) ? 1'b1 : r_busy;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_reg   <= '0;
      r_dhi   <= '0;
      r_dac0  <= '0;
      r_dac1  <= '0;
      r_sda   <= 1'b1;
      r_upd   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_bit   <= w_bit_nx;
      r_reg   <= w_reg_nx;
      r_dhi   <= w_dhi_nx;
      r_dac0  <= w_dac0_nx;
      r_dac1  <= w_dac1_nx;
      r_sda   <= w_sda_nx;
      r_upd   <= w_upd_nx;
      r_busy  <= w_busy_nx;
      r_err   <= w_err_nx;
    end
  end
`ifdef I2C_DAC_TARGET_READ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd <= 1'b0;
      r_lo <= 1'b0;
      r_tx <= 8'hFF;
    end else begin
      r_rd <= w_rd_nx;
      r_lo <= w_lo_nx;
      r_tx <= w_tx_nx;
    end
  end
`endif
  assign sda_o         = r_sda;
  assign dac0_value    = r_dac0;
  assign dac1_value    = r_dac1;
  assign dac_update    = r_upd;
  assign dac_update_ch = r_reg[0];
  assign busy          = r_busy;
  assign cmd_error     = r_err;
endmodule

// File: tb/tb_i2c_dac_target.sv
// tb_i2c_dac_target: bit-banged I2C master, spec-level DAC model and update scoreboard.
module tb_i2c_dac_target;
  localparam int H = 5;
  typedef struct packed { logic ch; logic [11:0] val; } upd_t;
  logic        clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  logic        sda_o, dac_update, dac_update_ch, busy, cmd_error, sda_bus;
  logic [11:0] dac0_value, dac1_value;
  logic [11:0] m_dac [2];
  logic        m_err = 1'b0;
  bit          live = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  upd_t        exp_q [$];
  assign sda_bus = m_sda & sda_o;
  always #5 clk = ~clk;
  i2c_dac_target dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scl_i         (m_scl),
    .sda_i         (sda_bus),
    .sda_o         (sda_o),
    .dac0_value    (dac0_value),
    .dac1_value    (dac1_value),
    .dac_update    (dac_update),
    .dac_update_ch (dac_update_ch),
    .busy          (busy),
    .cmd_error     (cmd_error)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    upd_t e;
    if (rst_n && dac_update) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_update: ch %0d dac0 %0h dac1 %0h", dac_update_ch, dac0_value, dac1_value);
      end else begin
        e = exp_q.pop_front();
        check("upd_ch", 32'(dac_update_ch), 32'(e.ch));
        check("upd_val", 32'(dac_update_ch ? dac1_value : dac0_value), 32'(e.val));
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_start();
    m_sda = 1'b1; tick(H);
    m_scl = 1'b1; tick(2 * H);
    m_sda = 1'b0; tick(2 * H);
    m_scl = 1'b0; tick(H);
  endtask
  task automatic do_stop();
    m_sda = 1'b0; tick(H);
    m_scl = 1'b1; tick(2 * H);
    m_sda = 1'b1; tick(2 * H);
    live = 1'b0;
  endtask
  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(H);
      m_scl = 1'b1; tick(2 * H);
      m_scl = 1'b0; tick(H);
    end
    m_sda = 1'b1; tick(H);
    m_scl = 1'b1; tick(H);
    ack = !sda_bus; tick(H);
    m_scl = 1'b0; tick(H);
  endtask
  task automatic rbyte(input bit mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; tick(H);
      m_scl = 1'b1; tick(H);
      b[i] = sda_bus; tick(H);
      m_scl = 1'b0; tick(H);
    end
    m_sda = !mack; tick(H);
    m_scl = 1'b1; tick(2 * H);
    m_scl = 1'b0; tick(H);
    m_sda = 1'b1;
  endtask
  task automatic send_addr(input logic [7:0] a);
    logic ack;
    do_start();
    wbyte(a, ack);
    live = (a == 8'hC0);
    check("addr_ack", 32'(ack), 32'(live));
    check("busy_addr", 32'(busy), 32'(live));
  endtask
  task automatic send_cmd(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input bit trunc);
    logic ack;
    bit legal;
    if (!live) return;
    legal = c[7:3] < 5'd2 && c[2:1] == 2'b00;
`ifdef I2C_DAC_TARGET_READ_EN
    legal = legal || (c[7:3] < 5'd2 && c[2:1] == 2'b11);
`endif
    wbyte(c, ack);
    check("cmd_ack", 32'(ack), 32'(legal));
    if (!legal) begin
      m_err = 1'b1;
      live = 1'b0;
      check("cmd_error_set", 32'(cmd_error), 32'd1);
      check("busy_nack", 32'(busy), 32'd0);
      return;
    end
    wbyte(h, ack);
    check("dhi_ack", 32'(ack), 32'd1);
    if (trunc) return;
    exp_q.push_back('{ch: c[3], val: {h[3:0], l}});
    m_dac[c[3]] = {h[3:0], l};
    wbyte(l, ack);
    check("dlo_ack", 32'(ack), 32'd1);
  endtask
  task automatic end_xfer();
    do_stop();
    check("busy_stop", 32'(busy), 32'd0);
    check("dac0", 32'(dac0_value), 32'(m_dac[0]));
    check("dac1", 32'(dac1_value), 32'(m_dac[1]));
    check("cmd_error", 32'(cmd_error), 32'(m_err));
  endtask
  initial begin
    logic [7:0] a, c, h, l, rb;
    logic       ack;
    int         n;
    m_dac[0] = '0;
    m_dac[1] = '0;
    tick(5);
    check("rst_sda_o", 32'(sda_o), 32'd1);
    check("rst_dac0", 32'(dac0_value), 32'd0);
    check("rst_dac1", 32'(dac1_value), 32'd0);
    check("rst_update", 32'(dac_update), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_error", 32'(cmd_error), 32'd0);
    rst_n = 1'b1;
    tick(5);
    send_addr(8'hC0); send_cmd(8'h00, 8'h0A, 8'hBC, 1'b0); end_xfer();
    send_addr(8'hC2); end_xfer();
    send_addr(8'hC0); send_cmd(8'h00, 8'h01, 8'h23, 1'b0); send_cmd(8'h08, 8'h0F, 8'hFF, 1'b0); end_xfer();
    send_addr(8'hC0); send_cmd(8'h10, 8'h00, 8'h00, 1'b0); end_xfer();
    send_addr(8'hC0); send_cmd(8'h00, 8'h05, 8'h00, 1'b1); end_xfer();
    for (int t = 0; t < 20; t++) begin
      a = ($urandom_range(0, 3) == 0) ? {7'($urandom_range(0, 127)), 1'b0} : 8'hC0;
      send_addr(a);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) != 0) c = {4'b0000, 1'($urandom_range(0, 1)), 2'b00, 1'($urandom_range(0, 1))};
        else if ($urandom_range(0, 1) == 1) c = {5'($urandom_range(2, 31)), 2'b00, 1'b0};
        else c = {5'($urandom_range(0, 1)), 2'($urandom_range(1, 2)), 1'b1};
        h = 8'($urandom);
        l = 8'($urandom);
        send_cmd(c, h, l, k == n - 1 && $urandom_range(0, 5) == 0);
      end
      end_xfer();
    end
    send_addr(8'hC0); send_cmd(8'h08, 8'h07, 8'h65, 1'b0);
    m_sda = 1'b0; tick(H);
    m_scl = 1'b1; tick(H);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("midrst_sda_o", 32'(sda_o), 32'd1);
    check("midrst_dac0", 32'(dac0_value), 32'd0);
    check("midrst_dac1", 32'(dac1_value), 32'd0);
    check("midrst_update", 32'(dac_update), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_error", 32'(cmd_error), 32'd0);
    m_dac[0] = '0;
    m_dac[1] = '0;
    m_err = 1'b0;
    live = 1'b0;
    m_sda = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
`ifdef I2C_DAC_TARGET_READ_EN
    send_addr(8'hC0); send_cmd(8'h00, 8'h0A, 8'hBC, 1'b0); send_cmd(8'h06, 8'h00, 8'h00, 1'b1);
    do_start();
    wbyte(8'hC1, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    rbyte(1'b1, rb);
    check("rd_hi", 32'(rb), 32'h0A);
    rbyte(1'b0, rb);
    check("rd_lo", 32'(rb), 32'hBC);
    end_xfer();
`else
    send_addr(8'hC0); send_cmd(8'h00, 8'h0A, 8'hBC, 1'b0); send_cmd(8'h06, 8'h00, 8'h00, 1'b0); end_xfer();
    send_addr(8'hC1); end_xfer();
`endif
    tick(10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_dac_target.md
# i2c_dac_target

I2C target (responder) that emulates the MCP47FEB-style dual 12-bit DAC register interface. It decodes the write sequence our I2C DAC driver emits (address, command byte, value high, value low) and presents the received values to fabric logic. It sits behind the board I2C pins for loopback and self-test, and can stand in for the physical DAC in simulation.

## Interface

Parameters:
- `TARGET_ADDR`, default 7'b110_0000: 7-bit address this block answers to.
- `NUM_REGS`, default 2: number of implemented volatile DAC registers (reg 0 and reg 1).

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Synchronous and active-low.
- `scl_i`, input, 1: raw SCL pin level (asynchronous).
- `sda_i`, input, 1: raw SDA pin level (asynchronous).
- `sda_o`, output, 1: open-drain SDA drive. 0 pulls SDA low; 1 releases it. SCL is never stretched.
- `dac0_value`, output, 12: last value committed to register 0.
- `dac1_value`, output, 12: last value committed to register 1.
- `dac_update`, output, 1: one-cycle pulse on each commit.
- `dac_update_ch`, output, 1: register index of the commit; valid while `dac_update` is high.
- `busy`, output, 1: high from an address match until STOP or until the block returns to IDLE.
- `cmd_error`, output, 1: sticky flag, set when a command byte is NACKed; cleared by reset only.

## Operation

- **Input sync:** SCL and SDA each pass through a 2-FF synchronizer; all logic uses the synced levels.
- **Bus events:**
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
  - Data bits are sampled on the synced SCL rising edge, MSB first.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. If bits[7:1] == `TARGET_ADDR` and R/W = 0, go to ADDR_ACK. Any mismatch, or R/W = 1 when the read feature is off, returns to IDLE (no ACK).
  - ADDR_ACK: drive the ACK bit, then go to CMD.
  - CMD: shift in the command byte = {reg[4:0], cmd[1:0], x}. Legal when reg < `NUM_REGS` and cmd = 2'b00 (write); go to CMD_ACK. Otherwise NACK, set `cmd_error`, go to IDLE.
  - CMD_ACK: ACK, then go to DHI.
  - DHI: shift in the high byte; bits[3:0] are kept as value[11:8] and bits[7:4] are ignored. ACK, then go to DLO.
  - DLO: shift in the low byte. ACK, then commit in the same cycle as the 8th-bit sample: write the selected register and pulse `dac_update`. Then go to CMD (continuous mode: the next byte is a new command byte).
- **ACK drive:** `sda_o` goes to 0 on the first synced SCL falling edge after the 8th bit and returns to 1 on the next synced SCL falling edge (after the 9th clock).
- **STOP in any state:** go to IDLE, `busy` = 0, `sda_o` = 1. A partially received value is discarded and the registers are untouched.
- **START in any non-IDLE state (repeated start):** go to ADDR and clear the bit counter. A partial value is discarded.
- **START and STOP detected in the same cycle:** impossible by construction, since only one SDA edge exists per sample.

## Timing

- **Reset values:** `sda_o` = 1, `dac0_value` = `dac1_value` = 0, `dac_update` = 0, `dac_update_ch` = 0, `busy` = 0, `cmd_error` = 0, state = IDLE.
- **Pin-to-detection latency:** 2 clk sync, plus 1 clk edge detect.
- **Clock requirement:** each SCL high and low phase lasts at least 6 clk. Our driver's prescale of 20 gives about 20 clk per phase.
- **Output update:** `dac_update` is asserted 3 clk after the SCL rising edge of the 8th bit of the low byte. `dacN_value` shows the new value in that same cycle.
- **ACK release:** `sda_o` changes 3 clk after the SCL falling edge, which leaves at least 3 clk of setup before SCL rises.
- **`busy`:** rises in the cycle ADDR_ACK is entered and falls in the cycle IDLE is entered.

## Configuration

- **`I2C_DAC_TARGET_READ_EN` defined:**
  - cmd = 2'b11 is legal and is ACKed.
  - After a repeated START with address + R, the block returns {4'b0000, value[11:8]}, then value[7:0], for the latched register.
  - Each data bit is driven on the SCL falling edge.
  - A master ACK after the low byte wraps back to the high byte; a master NACK goes to IDLE.
- **Not defined:** cmd = 2'b11 is NACKed like any other illegal command, and R/W = 1 addresses are ignored.

## Structure

- **Package `i2c_dac_pkg`:**
  - constants: default address 7'b110_0000; register codes 0/1; CMD_WRITE = 2'b00; CMD_READ = 2'b11.
  - the state enum.
- **Sub-module `i2c_bus_sync`:** the 2-FF synchronizers, plus SCL rise/fall and START/STOP pulse generation.

## Test plan

- Write to addr 0x60, cmd 0x00, data 0x0A, 0xBC, then STOP: `dac0_value` = 0xABC, one `dac_update` pulse with ch = 0, and an ACK on all 4 bytes.
- Write to addr 0x61: no ACK, `busy` stays 0, registers unchanged.
- Continuous: 0x60, then 0x00 0x01 0x23, then 0x08 0x0F 0xFF: `dac0_value` = 0x123, `dac1_value` = 0xFFF, two pulses with ch = 0 then 1.
- Command 0x10 (reg 2): NACK on the command byte, `cmd_error` = 1, return to IDLE.
- STOP after the high byte 0x05: no update pulse, value unchanged. Asserting `rst_n` = 0 mid-byte returns all outputs to their reset values on the next clk.
- With `I2C_DAC_TARGET_READ_EN`: write 0x0A 0xBC to reg 0, send cmd 0x06, repeated START, then 0xC1: the master reads 0x0A then 0xBC.
